// File: rtl/free_list_if.sv
// free_list_if: rename-side and commit-side signals of the physical-register free list.
// The slave modport is the free list itself; the master modport is rename/commit/recovery.
interface free_list_if #(
  parameter int unsigned PHYS_REG_BITS = 6,
  parameter int unsigned CNT_BITS      = 6
);

  logic                     dequeue;
  logic [PHYS_REG_BITS-1:0] phys_reg;
  logic                     is_free_list_empty;
  logic                     is_free_list_full;
  logic [CNT_BITS-1:0]      free_count;
  logic                     enqueue;
  logic [PHYS_REG_BITS-1:0] enqueue_preg;
  logic                     flush;
  logic                     overflow_err;

  modport master (
    output dequeue,
    output enqueue,
    output enqueue_preg,
    output flush,
    input  phys_reg,
    input  is_free_list_empty,
    input  is_free_list_full,
    input  free_count,
    input  overflow_err
  );

  modport slave (
    input  dequeue,
    input  enqueue,
    input  enqueue_preg,
    input  flush,
    output phys_reg,
    output is_free_list_empty,
    output is_free_list_full,
    output free_count,
    output overflow_err
  );

endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical-register indices feeding rename.
// Entries are dequeued at the head by rename and returned at the tail by commit;
// a flush makes every non-architectural register free again (count back to DEPTH).
// Optional feature macro: FREE_LIST_BYPASS_EN -- when the list is empty, a legal
// enqueue is forwarded straight to phys_reg and can be consumed in the same cycle.
module free_list #(
  parameter int unsigned PHYS_REGS     = 64,
  parameter int unsigned ARCH_REGS     = 32,
  parameter int unsigned PHYS_REG_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  free_list_if.slave  fl_if
);

  localparam int unsigned DEPTH    = PHYS_REGS - ARCH_REGS;
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage and pointers
  logic [PHYS_REG_BITS-1:0] r_mem [DEPTH];
  logic [PTR_BITS-1:0]      r_head;
  logic [PTR_BITS-1:0]      r_tail;
  logic [CNT_BITS-1:0]      r_count;
  logic                     r_overflow;

  // Decoded per-cycle actions
  logic                     w_empty;
  logic                     w_full;
  logic                     w_enq_legal;
  logic                     w_enq_ok;
  logic                     w_ovf_set;
  logic                     w_bypass;
  logic                     w_bypass_take;
  logic                     w_wr_en;
  logic                     w_head_adv;
  logic [PTR_BITS-1:0]      w_head_inc;
  logic [PTR_BITS-1:0]      w_tail_inc;

  // Pointer increment with explicit wrap so non-power-of-two depths also work
  function automatic logic [PTR_BITS-1:0] f_inc(input logic [PTR_BITS-1:0] p);
    if (p == PTR_BITS'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_BITS'(1);
  endfunction

  // Classify the requests of this cycle against the registered state
  always_comb begin
    w_empty       = (r_count == '0);
    w_full        = (r_count == CNT_BITS'(DEPTH));
    w_enq_legal   = fl_if.enqueue && (fl_if.enqueue_preg != '0);
    w_enq_ok      = w_enq_legal && !w_full;
    w_ovf_set     = w_enq_legal && w_full;
`ifdef FREE_LIST_BYPASS_EN
    w_bypass      = w_empty && w_enq_legal;
`else
    w_bypass      = 1'b0;
`endif
    // A same-cycle dequeue of the bypassed register leaves storage untouched
    w_bypass_take = w_bypass && fl_if.dequeue && !fl_if.flush;
    w_wr_en       = w_enq_ok && !w_bypass_take;
    w_head_adv    = fl_if.dequeue && !w_empty && !fl_if.flush;
    w_head_inc    = f_inc(r_head);
    w_tail_inc    = f_inc(r_tail);
  end

  // Head entry and status flags, combinational from registered state
  always_comb begin
    fl_if.phys_reg           = r_mem[r_head];
    fl_if.is_free_list_empty = w_empty;
    if (w_bypass) begin
      fl_if.phys_reg           = fl_if.enqueue_preg;
      fl_if.is_free_list_empty = 1'b0;
    end
    fl_if.is_free_list_full  = w_full;
    fl_if.free_count         = r_count;
    fl_if.overflow_err       = r_overflow;
  end

  // Storage write, pointer/count update, flush recovery and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= PHYS_REG_BITS'(int'(ARCH_REGS) + i);
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= CNT_BITS'(DEPTH);
      r_overflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_en) begin
        r_mem[r_tail] <= fl_if.enqueue_preg;
        r_tail        <= w_tail_inc;
      end
      if (fl_if.flush) begin
        r_head  <= w_wr_en ? w_tail_inc : r_tail;
        r_count <= CNT_BITS'(DEPTH);
      end else begin
        if (w_head_adv && !w_bypass_take) begin
          r_head <= w_head_inc;
        end
        if (w_wr_en && !w_head_adv) begin
          r_count <= r_count + CNT_BITS'(1);
        end else if (!w_wr_en && w_head_adv && !w_bypass_take) begin
          r_count <= r_count - CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical-register indices for the out-of-order core's rename stage. It sits directly upstream of rename/dispatch: it supplies the next free physical destination register (`phys_reg`) and an empty flag, and it consumes `dequeue` each time an instruction is renamed. Registers come back in two ways: retiring instructions return the stale mapping through `enqueue`, and a pipeline flush restores the list to its architectural-only (full) state.

## Interface
Parameters:
- `PHYS_REGS`, 64: total physical registers.
- `ARCH_REGS`, 32: architectural registers; p0..p(ARCH_REGS-1) are never in the list at reset.
- `PHYS_REG_BITS`, 6: index width, equal to $clog2(PHYS_REGS).
- Derived: `DEPTH` = PHYS_REGS-ARCH_REGS (32); `CNT_BITS` = $clog2(DEPTH+1).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `dequeue` in 1: rename consumes the head entry this cycle.
- `phys_reg` out PHYS_REG_BITS: head entry, read combinationally from storage.
- `is_free_list_empty` out 1: count == 0.
- `is_free_list_full` out 1: count == DEPTH.
- `free_count` out CNT_BITS: number of valid entries.
- `enqueue` in 1: commit returns a register.
- `enqueue_preg` in PHYS_REG_BITS: register being returned.
- `flush` in 1: mispredict recovery; all speculatively allocated registers become free.
- `overflow_err` out 1: sticky flag, set on an illegal enqueue.

## Operation
- Storage: DEPTH × PHYS_REG_BITS array, with `head` and `tail` pointers of $clog2(DEPTH) bits and a `count`.
- Reset state:
  - entry i = ARCH_REGS+i (32..63);
  - head = 0, tail = 0, count = DEPTH;
  - `is_free_list_full` = 1, `is_free_list_empty` = 0, `free_count` = DEPTH, `overflow_err` = 0;
  - `phys_reg` = ARCH_REGS (32).
- Dequeue: accepted only when count != 0. Effect: head ← head+1 (mod DEPTH), count decrements. A dequeue while empty is ignored and the state is unchanged.
- Enqueue: accepted only when count != DEPTH and enqueue_preg != 0. Effect: storage[tail] ← enqueue_preg, tail ← tail+1 (mod DEPTH), count increments.
  - enqueue_preg == 0 (the x0 mapping) is silently dropped.
  - Enqueue while full is dropped and sets `overflow_err` (cleared only by rst).
- Simultaneous accepted enqueue and dequeue: both pointers advance and count is unchanged.
  - When empty: enqueue accepted, dequeue ignored; no bypass, except as described under Configuration.
- Flush (highest priority; dequeue is ignored in that cycle):
  - If an enqueue is also accepted that cycle: it is written at tail, tail advances, then head ← new tail.
  - Otherwise head ← tail.
  - In both cases count ← DEPTH. This relies on the retirement RAT holding exactly ARCH_REGS mappings.
- Pointer wrap: power-of-two DEPTH wraps naturally; non-power-of-two DEPTH wraps explicitly at DEPTH-1 → 0.
- All state is updated on the rising edge of `clk`. `phys_reg` and the flags reflect the registered state only.

## Timing
- `phys_reg` is valid in the same cycle as `is_free_list_empty` == 0. The consumer samples it in the cycle it asserts `dequeue`.
- After a dequeue, the next entry appears at `phys_reg` in the following cycle (1-cycle pointer update).
- An enqueued register is visible at the head no earlier than 1 cycle after the enqueue, and only once it reaches the head.
- The flags are combinational from `count`. The consumer may register them, which gives an extra cycle of latency on its side; the list tolerates the resulting ignored dequeues while empty.
- Reset asserted mid-operation: all state returns to the reset state immediately (asynchronous). The first operation is accepted on the first rising edge after deassertion.

## Configuration
- `FREE_LIST_BYPASS_EN` defined: when count == 0 and a legal enqueue is present, `phys_reg` = enqueue_preg and `is_free_list_empty` = 0 combinationally.
  - A dequeue in that cycle consumes the bypassed register directly: no write, pointers and count unchanged.
  - Flush still takes priority over this path.
- `FREE_LIST_BYPASS_EN` undefined: no bypass; the empty-list behaviour is exactly as described under Operation.

## Test plan
- Reset, then hold 32 consecutive dequeues:
  - `phys_reg` sequence is 32..63;
  - `is_free_list_empty` = 1 after the 32nd dequeue;
  - a 33rd dequeue leaves head and count unchanged.
- After draining to empty, enqueue 45, then 7, on consecutive cycles, then dequeue twice: `phys_reg` = 45 then 7, and `free_count` goes 0→1→2→1→0.
- From the reset (full) state, enqueue 50: the entry is dropped, `overflow_err` = 1 and stays set; then enqueue 0 from a partially empty list: dropped, and count is unchanged.
- Dequeue 10 entries, then assert flush together with an enqueue of 40:
  - next cycle `free_count` = 32 and `is_free_list_full` = 1;
  - 32 following dequeues return every stored entry exactly once, including 40.
- With count = 5, hold enqueue (60) and dequeue for 40 cycles: count stays 5, and both pointers wrap past 31→0 with correct ordering.
- With `FREE_LIST_BYPASS_EN`, on an empty list assert enqueue 33 and dequeue together: `phys_reg` = 33 in that cycle, and next cycle count = 0.
